// File: rtl/mc_fifo_pkg.sv
// Shared helpers for the multi-channel FIFO family: width derivation,
// default-configuration pointer/count types and threshold sanity checks.
package mc_fifo_pkg;

  // Ceiling log2 for elaboration-time width calculations.
  function automatic int clog2_f(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Address bits needed to index one channel's DEPTH words.
  function automatic int addr_w_f(input int depth);
    return clog2_f(depth);
  endfunction

  // Channel select width keeps at least one code above NUM_CH-1,
  // so an out-of-range channel can always be presented and ignored.
  function automatic int ch_w_f(input int num_ch);
    return clog2_f(num_ch + 1);
  endfunction

  // Width of the channel part of the shared memory address.
  function automatic int ch_idx_w_f(input int num_ch);
    return (num_ch < 2) ? 1 : clog2_f(num_ch);
  endfunction

  // Thresholds must lie inside the 0..DEPTH count range to be meaningful.
  function automatic bit thresh_ok_f(input int depth, input int af, input int ae);
    return (af >= 1) && (af <= depth) && (ae >= 0) && (ae < depth);
  endfunction

  // Types for the default configuration (DEPTH = 16).
  localparam int DEF_DEPTH  = 16;
  localparam int DEF_ADDR_W = addr_w_f(DEF_DEPTH);
  typedef logic [DEF_ADDR_W:0] ptr_t;
  typedef logic [DEF_ADDR_W:0] count_t;

endpackage

// File: rtl/mc_fifo_ch_ctrl.sv
// Per-channel control for mc_sync_fifo: write/read pointers, fill count and
// registered status flags. Optional sticky error flags when
// FIFO_ERR_STICKY_EN is defined.
// Handshake: a request is accepted on the clock edge when req_i is high and
// the pre-edge flag allows it (write needs !full, read needs !empty); the
// matching *_acc_o is high for that cycle. There is no back-pressure signal.
module mc_fifo_ch_ctrl
  import mc_fifo_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = 14,
  parameter int AE_THRESH = 2,
  localparam int ADDR_W   = addr_w_f(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_req_i,
  input  logic              rd_req_i,
`ifdef FIFO_ERR_STICKY_EN
  input  logic              err_clr_i,
  output logic              ovf_err_o,
  output logic              unf_err_o,
`endif
  output logic              wr_acc_o,
  output logic              rd_acc_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic [ADDR_W:0]   count_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              af_o,
  output logic              ae_o
);

  localparam logic [ADDR_W:0] AF_C = (ADDR_W + 1)'(AF_THRESH);
  localparam logic [ADDR_W:0] AE_C = (ADDR_W + 1)'(AE_THRESH);

  logic [ADDR_W:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
  logic            full_q, full_d, empty_q, empty_d, af_q, af_d, ae_q, ae_d;

  // Acceptance uses pre-edge flags, so full+read and empty+write resolve naturally.
  assign wr_acc_o  = wr_req_i & ~full_q;
  assign rd_acc_o  = rd_req_i & ~empty_q;
  assign wr_addr_o = wr_ptr_q[ADDR_W-1:0];
  assign rd_addr_o = rd_ptr_q[ADDR_W-1:0];
  assign count_o   = count_q;
  assign full_o    = full_q;
  assign empty_o   = empty_q;
  assign af_o      = af_q;
  assign ae_o      = ae_q;

  // Next pointers and the flags they imply after this edge's accepted ops.
  always_comb begin
    wr_ptr_d = wr_ptr_q + {{ADDR_W{1'b0}}, wr_acc_o};
    rd_ptr_d = rd_ptr_q + {{ADDR_W{1'b0}}, rd_acc_o};
    count_d  = wr_ptr_d - rd_ptr_d;
    empty_d  = (wr_ptr_d == rd_ptr_d);
    full_d   = (wr_ptr_d[ADDR_W] != rd_ptr_d[ADDR_W]) &&
               (wr_ptr_d[ADDR_W-1:0] == rd_ptr_d[ADDR_W-1:0]);
    af_d     = (count_d >= AF_C);
    ae_d     = (count_d <= AE_C);
  end

  // Pointer, count and flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
    end
  end

`ifdef FIFO_ERR_STICKY_EN
  logic ovf_q, ovf_d, unf_q, unf_d;

  // Sticky overflow/underflow; a clear in the same cycle as a new error wins.
  always_comb begin
    ovf_d = ovf_q | (wr_req_i & full_q);
    unf_d = unf_q | (rd_req_i & empty_q);
    if (err_clr_i) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
  end

  // Error flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign ovf_err_o = ovf_q;
  assign unf_err_o = unf_q;
`endif

endmodule

// File: rtl/mc_sync_fifo.sv
// Multi-channel single-clock FIFO: NUM_CH logical queues in one shared
// memory of NUM_CH*DEPTH words, addressed as {channel, pointer}.
// Optional feature macro: FIFO_ERR_STICKY_EN (sticky ovf_err/unf_err + err_clr).
// Requests on a channel index >= NUM_CH never select a channel and are ignored.
module mc_sync_fifo
  import mc_fifo_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int NUM_CH    = 4,
  parameter int AF_THRESH = 14,
  parameter int AE_THRESH = 2,
  localparam int ADDR_W   = addr_w_f(DEPTH),
  localparam int CH_W     = ch_w_f(NUM_CH)
) (
  input  logic                       clk,
  input  logic                       rst,
`ifdef FIFO_ERR_STICKY_EN
  input  logic                       err_clr,
  output logic [NUM_CH-1:0]          ovf_err,
  output logic [NUM_CH-1:0]          unf_err,
`endif
  input  logic                       wr_req,
  input  logic [CH_W-1:0]            wr_ch,
  input  logic [DATA_W-1:0]          data_in,
  input  logic                       rd_req,
  input  logic [CH_W-1:0]            rd_ch,
  output logic [DATA_W-1:0]          data_out,
  output logic                       rd_valid,
  output logic [NUM_CH-1:0]          fifo_full,
  output logic [NUM_CH-1:0]          fifo_empty,
  output logic [NUM_CH-1:0]          almost_full,
  output logic [NUM_CH-1:0]          almost_empty,
  output logic [NUM_CH*(ADDR_W+1)-1:0] fill_level
);

  localparam int CHI_W  = ch_idx_w_f(NUM_CH);
  localparam int MEM_AW = CHI_W + ADDR_W;

  if (!thresh_ok_f(DEPTH, AF_THRESH, AE_THRESH) || DEPTH < 4 || NUM_CH < 1 ||
      (1 << ADDR_W) != DEPTH) begin : g_bad_cfg
    $error("mc_sync_fifo: illegal DEPTH/NUM_CH/threshold configuration");
  end

  logic [NUM_CH-1:0] wr_sel, rd_sel, wr_acc_v, rd_acc_v;
  logic [ADDR_W-1:0] wr_addr_a [NUM_CH];
  logic [ADDR_W-1:0] rd_addr_a [NUM_CH];
  logic [ADDR_W-1:0] wr_low, rd_low;
  logic [MEM_AW-1:0] mem_waddr, mem_raddr;
  logic [DATA_W-1:0] mem [NUM_CH*DEPTH];
  logic [DATA_W-1:0] data_q;
  logic              valid_q;

  // Decode channel selects and pick the selected channel's memory offsets.
  always_comb begin
    wr_sel = '0;
    rd_sel = '0;
    wr_low = '0;
    rd_low = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      wr_sel[c] = wr_req & (wr_ch == CH_W'(c));
      rd_sel[c] = rd_req & (rd_ch == CH_W'(c));
      if (wr_ch == CH_W'(c)) wr_low = wr_addr_a[c];
      if (rd_ch == CH_W'(c)) rd_low = rd_addr_a[c];
    end
    mem_waddr = {wr_ch[CHI_W-1:0], wr_low};
    mem_raddr = {rd_ch[CHI_W-1:0], rd_low};
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    mc_fifo_ch_ctrl #(
      .DEPTH     (DEPTH),
      .AF_THRESH (AF_THRESH),
      .AE_THRESH (AE_THRESH)
    ) u_ctrl (
      .clk       (clk),
      .rst       (rst),
      .wr_req_i  (wr_sel[c]),
      .rd_req_i  (rd_sel[c]),
`ifdef FIFO_ERR_STICKY_EN
      .err_clr_i (err_clr),
      .ovf_err_o (ovf_err[c]),
      .unf_err_o (unf_err[c]),
`endif
      .wr_acc_o  (wr_acc_v[c]),
      .rd_acc_o  (rd_acc_v[c]),
      .wr_addr_o (wr_addr_a[c]),
      .rd_addr_o (rd_addr_a[c]),
      .count_o   (fill_level[c*(ADDR_W+1) +: (ADDR_W+1)]),
      .full_o    (fifo_full[c]),
      .empty_o   (fifo_empty[c]),
      .af_o      (almost_full[c]),
      .ae_o      (almost_empty[c])
    );
  end

  // Shared storage; only an accepted write touches it, contents not reset.
  always_ff @(posedge clk) begin
    if (|wr_acc_v) mem[mem_waddr] <= data_in;
  end

  // Registered read port: data_out holds between reads, rd_valid pulses per read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= |rd_acc_v;
      if (|rd_acc_v) data_q <= mem[mem_raddr];
    end
  end

  assign data_out = data_q;
  assign rd_valid = valid_q;

endmodule

// File: tb/tb_mc_sync_fifo.sv
// Directed bench for mc_sync_fifo (default parameters). Build with
// FIFO_ERR_STICKY_EN defined to also exercise the sticky error flags.
`timescale 1ns/1ps
module tb_mc_sync_fifo;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int NUM_CH = 4;
  localparam int CH_W   = 3;
  localparam int LW     = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                   wr_req, rd_req;
  logic [CH_W-1:0]        wr_ch, rd_ch;
  logic [DATA_W-1:0]      data_in, data_out;
  logic                   rd_valid;
  logic [NUM_CH-1:0]      fifo_full, fifo_empty, almost_full, almost_empty;
  logic [NUM_CH*LW-1:0]   fill_level;
  logic                   err_clr;
`ifdef FIFO_ERR_STICKY_EN
  logic [NUM_CH-1:0]      ovf_err, unf_err;
`endif

  mc_sync_fifo #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_CH(NUM_CH), .AF_THRESH(14), .AE_THRESH(2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
`ifdef FIFO_ERR_STICKY_EN
    .err_clr      (err_clr),
    .ovf_err      (ovf_err),
    .unf_err      (unf_err),
`endif
    .wr_req       (wr_req),
    .wr_ch        (wr_ch),
    .data_in      (data_in),
    .rd_req       (rd_req),
    .rd_ch        (rd_ch),
    .data_out     (data_out),
    .rd_valid     (rd_valid),
    .fifo_full    (fifo_full),
    .fifo_empty   (fifo_empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .fill_level   (fill_level)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic              exp_v_q[$];
  logic [DATA_W-1:0] last_data;
  logic              mon_en;
  logic              mon_ev;

  // Reference model of the queues.
  logic [DATA_W-1:0] m_mem [NUM_CH][DEPTH];
  int                m_wp [NUM_CH];
  int                m_rp [NUM_CH];
  int                m_cnt[NUM_CH];
  logic [NUM_CH-1:0] m_ovf, m_unf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_wp[c] = 0; m_rp[c] = 0; m_cnt[c] = 0;
    end
    m_ovf = '0;
    m_unf = '0;
    exp_q.delete();
    exp_v_q.delete();
    last_data = '0;
  endtask

  // ---------------- monitor: pops one expectation per clock ----------------
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      mon_ev = (exp_v_q.size() > 0) ? exp_v_q.pop_front() : 1'b0;
      chk("rd_valid", {31'd0, rd_valid}, {31'd0, mon_ev});
      if (mon_ev) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL data_queue: read expected but scoreboard empty (t=%0t)", $time);
        end else begin
          last_data = exp_q.pop_front();
          chk("data_out", {24'd0, data_out}, {24'd0, last_data});
        end
      end else begin
        chk("data_hold", {24'd0, data_out}, {24'd0, last_data});
      end
    end
  end

  // ---------------- driver: one clock of stimulus + model update ----------------
  task automatic cycle(input logic w, input logic [CH_W-1:0] wc, input logic [DATA_W-1:0] d,
                       input logic r, input logic [CH_W-1:0] rc);
    int wci, rci;
    bit wok, rok;
    wr_req = w; wr_ch = wc; data_in = d;
    rd_req = r; rd_ch = rc;
    wci = int'(wc);
    rci = int'(rc);
    wok = 1'b0;
    rok = 1'b0;
    if (w && wci < NUM_CH) begin
      if (m_cnt[wci] != DEPTH) wok = 1'b1;
      else if (!err_clr) m_ovf[wci] = 1'b1;
    end
    if (r && rci < NUM_CH) begin
      if (m_cnt[rci] != 0) rok = 1'b1;
      else if (!err_clr) m_unf[rci] = 1'b1;
    end
    if (err_clr) begin
      m_ovf = '0;
      m_unf = '0;
    end
    if (rok) begin
      exp_q.push_back(m_mem[rci][m_rp[rci]]);
      m_rp[rci] = (m_rp[rci] + 1) % DEPTH;
      m_cnt[rci]--;
    end
    if (wok) begin
      m_mem[wci][m_wp[wci]] = d;
      m_wp[wci] = (m_wp[wci] + 1) % DEPTH;
      m_cnt[wci]++;
    end
    exp_v_q.push_back(rok);
    @(negedge clk);
    wr_req = 1'b0;
    rd_req = 1'b0;
  endtask

  task automatic idle();
    cycle(1'b0, '0, '0, 1'b0, '0);
  endtask

  function automatic logic [LW-1:0] fill_of(input int c);
    return fill_level[c*LW +: LW];
  endfunction

  // Compare all registered status outputs with the model.
  task automatic check_flags(input string tag);
    logic [NUM_CH-1:0] ef, ee, eaf, eae;
    logic [NUM_CH*LW-1:0] efl;
    for (int c = 0; c < NUM_CH; c++) begin
      ef[c]  = (m_cnt[c] == DEPTH);
      ee[c]  = (m_cnt[c] == 0);
      eaf[c] = (m_cnt[c] >= 14);
      eae[c] = (m_cnt[c] <= 2);
      efl[c*LW +: LW] = LW'(m_cnt[c]);
    end
    chk({tag, ".fifo_full"},    {28'd0, fifo_full},    {28'd0, ef});
    chk({tag, ".fifo_empty"},   {28'd0, fifo_empty},   {28'd0, ee});
    chk({tag, ".almost_full"},  {28'd0, almost_full},  {28'd0, eaf});
    chk({tag, ".almost_empty"}, {28'd0, almost_empty}, {28'd0, eae});
    chk({tag, ".fill_level"},   {12'd0, fill_level},   {12'd0, efl});
`ifdef FIFO_ERR_STICKY_EN
    chk({tag, ".ovf_err"}, {28'd0, ovf_err}, {28'd0, m_ovf});
    chk({tag, ".unf_err"}, {28'd0, unf_err}, {28'd0, m_unf});
`endif
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1; err_clr = 1'b0;
    wr_req = 1'b0; wr_ch = '0; data_in = '0;
    rd_req = 1'b0; rd_ch = '0;
    model_reset();
    mon_en = 1'b1;
    #1;
    chk("rst.data_out",     {24'd0, data_out},     32'h0);
    chk("rst.rd_valid",     {31'd0, rd_valid},     32'h0);
    chk("rst.fifo_full",    {28'd0, fifo_full},    32'h0);
    chk("rst.fifo_empty",   {28'd0, fifo_empty},   32'hF);
    chk("rst.almost_full",  {28'd0, almost_full},  32'h0);
    chk("rst.almost_empty", {28'd0, almost_empty}, 32'hF);
    chk("rst.fill_level",   {12'd0, fill_level},   32'h0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Asynchronous reset applied mid-cycle clears state without a clock edge.
    cycle(1'b1, 3'd0, 8'h11, 1'b0, 3'd0);
    cycle(1'b1, 3'd2, 8'h22, 1'b0, 3'd0);
    check_flags("pre_rst");
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("async_rst.fifo_empty", {28'd0, fifo_empty}, 32'hF);
    chk("async_rst.fill_level", {12'd0, fill_level}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Fill ch1 to full, overflow attempt, then drain in order.
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 3'd1, 8'(i), 1'b0, 3'd0);
      chk("ch1.almost_full", {31'd0, almost_full[1]}, {31'd0, (i >= 13)});
    end
    chk("ch1.full_vec", {28'd0, fifo_full}, 32'h2);
    cycle(1'b1, 3'd1, 8'hEE, 1'b0, 3'd0);
    chk("ch1.overflow_fill", {27'd0, fill_of(1)}, 32'd16);
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 3'd0, 8'h00, 1'b1, 3'd1);
      check_flags("ch1.drain");
    end
    idle();

    // Interleaved channels stay independent.
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 3'd0, 8'hA0 + 8'(i), 1'b0, 3'd0);
      cycle(1'b1, 3'd3, 8'hB0 + 8'(i), 1'b0, 3'd0);
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, 3'd0, 8'h00, 1'b1, 3'd3);
    chk("ilv.ch0_fill", {27'd0, fill_of(0)}, 32'd4);
    chk("ilv.ch3_fill", {27'd0, fill_of(3)}, 32'd0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 3'd0, 8'h00, 1'b1, 3'd0);
    check_flags("ilv");

    // Ch2 full: simultaneous write+read -> oldest read, write dropped.
    for (int i = 0; i < 16; i++) cycle(1'b1, 3'd2, 8'h20 + 8'(i), 1'b0, 3'd0);
    cycle(1'b1, 3'd2, 8'h55, 1'b1, 3'd2);
    chk("ch2.full_wr_rd_fill", {27'd0, fill_of(2)}, 32'd15);
    for (int i = 0; i < 15; i++) cycle(1'b0, 3'd0, 8'h00, 1'b1, 3'd2);
    // Ch2 empty: simultaneous write+read -> write only, no fall-through.
    cycle(1'b1, 3'd2, 8'h66, 1'b1, 3'd2);
    chk("ch2.empty_wr_rd_fill", {27'd0, fill_of(2)}, 32'd1);
    chk("ch2.empty_wr_rd_valid", {31'd0, rd_valid}, 32'd0);
    cycle(1'b0, 3'd0, 8'h00, 1'b1, 3'd2);
    check_flags("ch2");

    // Pointer wrap on ch0 with concurrent write/read pairs.
    for (int i = 0; i < 3; i++) cycle(1'b1, 3'd0, 8'hC0 + 8'(i), 1'b0, 3'd0);
    for (int i = 0; i < 40; i++) begin
      cycle(1'b1, 3'd0, 8'(i), 1'b1, 3'd0);
      checks++;
      if (fill_of(0) > 5'd16) begin
        errors++;
        $display("FAIL wrap.fill_bound: got %0d expected <= 16", fill_of(0));
      end
    end
    chk("wrap.fill", {27'd0, fill_of(0)}, 32'd3);
    for (int i = 0; i < 3; i++) cycle(1'b0, 3'd0, 8'h00, 1'b1, 3'd0);
    check_flags("wrap");

    // Out-of-range channel indices change nothing.
    cycle(1'b1, 3'd4, 8'h99, 1'b0, 3'd0);
    cycle(1'b1, 3'd7, 8'h98, 1'b1, 3'd5);
    chk("oor.fifo_empty", {28'd0, fifo_empty}, 32'hF);
    check_flags("oor");

`ifdef FIFO_ERR_STICKY_EN
    // Underflow on ch3 is sticky until cleared; clear wins over a same-cycle set.
    cycle(1'b0, 3'd0, 8'h00, 1'b1, 3'd3);
    chk("err.unf_set", {28'd0, unf_err}, 32'h8);
    idle(); idle();
    chk("err.unf_held", {28'd0, unf_err}, 32'h8);
    err_clr = 1'b1;
    cycle(1'b0, 3'd0, 8'h00, 1'b1, 3'd3);
    err_clr = 1'b0;
    chk("err.clr_wins", {28'd0, unf_err}, 32'h0);
    for (int i = 0; i < 16; i++) cycle(1'b1, 3'd1, 8'(i), 1'b0, 3'd0);
    cycle(1'b1, 3'd1, 8'h77, 1'b0, 3'd0);
    chk("err.ovf_set", {28'd0, ovf_err}, 32'h2);
    check_flags("err");
    for (int i = 0; i < 16; i++) cycle(1'b0, 3'd0, 8'h00, 1'b1, 3'd1);
    err_clr = 1'b1;
    idle();
    err_clr = 1'b0;
    check_flags("err_clr");
`endif

    // Reset right after a read discards the pending valid immediately.
    cycle(1'b1, 3'd0, 8'h77, 1'b0, 3'd0);
    cycle(1'b0, 3'd0, 8'h00, 1'b1, 3'd0);
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("midrst.rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("midrst.fifo_empty", {28'd0, fifo_empty}, 32'hF);
    @(negedge clk);
    rst = 1'b0;
    idle(); idle();
    check_flags("final");

    mon_en = 1'b0;
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL leftover: %0d expected reads never seen", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "timeout");
  end

endmodule
